vga_fetch_arbiter: RTL and testbench
====================================

VGA_FETCH_ARBITER -- requirements
Module: vga_fetch_arbiter

Interface
REQ-001 Parameter NUM_LAYERS, default 4: number of vga_layer instances served, 1..4.
REQ-002 Parameter TAG_W, default 2: width of the memory read tag; 2**TAG_W SHALL be >= NUM_LAYERS.
REQ-003 clk  in  1  clock; the block SHALL use clock clk.
REQ-004 reset  in  1  reset; the block SHALL use reset reset, synchronous, active-high.
REQ-005 p2_pixel  in  1  pipeline presents a pixel this cycle.
REQ-006 p2_valid  in  NUM_LAYERS  per-layer fetch request for this pixel.
REQ-007 p2_addr  in  NUM_LAYERS x 26  per-layer byte address.
REQ-008 stall  out  1  holds the whole pixel pipeline, including every vga_layer.
REQ-009 mem_req  out  1  read request to the shared memory port.
REQ-010 mem_addr  out  26  word-aligned address, {p2_addr[25:2],2'b00}.
REQ-011 mem_tag  out  TAG_W  request tag, equal to the layer index.
REQ-012 mem_ack  in  1  memory accepted the current request.
REQ-013 mem_rvalid  in  1  read data valid.
REQ-014 mem_rtag  in  TAG_W  tag of the returned data.
REQ-015 mem_rdata  in  32  returned word.
REQ-016 p3_valid  out  1  pixel result valid for one cycle.
REQ-017 p3_mask  out  NUM_LAYERS  layers that hold data for this pixel.
REQ-018 p3_data  out  NUM_LAYERS x 32  per-layer fetched word.
REQ-019 p3_lane  out  NUM_LAYERS x 2  per-layer p2_addr[1:0].
REQ-020 err_tag  out  1  sticky flag: a response arrived with a tag not outstanding.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT and DONE, and stall SHALL be 1 exactly when the state is not IDLE, driven from registered state only.
REQ-022 IDLE, p2_pixel=1 and no p2_valid bit set: p3_valid=1 with p3_mask=0 next cycle; state stays IDLE.
REQ-023 IDLE, p2_pixel=1 and any p2_valid bit set: capture p2_valid into pending and p3_mask, capture addresses and lanes, go to ISSUE.
REQ-024 IDLE, p2_pixel=0: p2_valid is ignored.
REQ-025 ISSUE: present the lowest-index pending layer; mem_req, mem_addr and mem_tag SHALL remain stable until mem_ack.
REQ-026 mem_ack in ISSUE: clear that pending bit and set its outstanding bit; the next pending layer is presented the following cycle; after the last pending layer, go to WAIT.
REQ-027 mem_req SHALL be 0 outside ISSUE.
REQ-028 mem_rvalid with outstanding[mem_rtag]=1: store mem_rdata in p3_data[mem_rtag] and clear the bit, in any state; responses may arrive in any order and in the same cycle as an ack.
REQ-029 mem_rvalid with outstanding[mem_rtag]=0: ignore the data and set err_tag.
REQ-030 Transition to DONE when pending=0 and outstanding=0 (from WAIT, or from ISSUE when the final ack and the final response coincide); DONE asserts p3_valid for one cycle, then returns to IDLE, releasing stall.
REQ-031 p3_data and p3_lane SHALL hold their values until the next capture; p3_data entries for unmasked layers are don't-care.
REQ-032 Minimum latency with k valid layers and single-cycle ack/response: capture cycle, k ISSUE cycles, DONE cycle.

Reset
REQ-033 Reset SHALL force state IDLE, stall=0, mem_req=0, p3_valid=0, pending=0, outstanding=0, err_tag=0.
REQ-034 Reset mid-transaction SHALL abandon the pixel; the memory port is reset by the same reset, so no stale responses follow.
REQ-035 p3_data, p3_lane and p3_mask are not reset.

Structure
REQ-036 The state enum, MAX_LAYERS=4 and ADDR_W=26 SHALL live in the shared package vga_pkg.
REQ-037 A sub-module vga_prio_pick SHALL provide combinational lowest-index-first selection, giving index and one-hot outputs.

Verification
REQ-038 Pixel with p2_pixel=1 and p2_valid=0000 -> p3_valid=1 next cycle, mask 0000, stall never set.
REQ-039 p2_valid=0101, addr0=0x100, addr2=0x20A, immediate acks and responses -> mem_addr 0x100 (tag 0) then 0x208 (tag 2); lane2=2; p3_valid on the fourth cycle after capture.
REQ-040 p2_valid=1111, responses returned in order 3,1,0,2 -> p3_data matches by tag; p3_valid only after the last response.
REQ-041 mem_ack held low 5 cycles on layer 1 -> mem_req, mem_addr and mem_tag stable throughout; stall held.
REQ-042 mem_rvalid with tag 3 while nothing is outstanding -> err_tag=1 and stays set; p3 outputs unaffected.
REQ-043 Reset asserted in WAIT with two layers outstanding -> next cycle IDLE, stall=0, mem_req=0; the next pixel is fetched normally.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: definitions shared by the VGA fetch path.
//   MAX_LAYERS : most vga_layer instances a single arbiter can serve
//   ADDR_W     : byte address width of the shared memory port
//   DATA_W     : width of one fetched word
//   state_t    : fetch arbiter FSM state encoding
package vga_pkg;

    localparam int MAX_LAYERS = 4;
    localparam int ADDR_W     = 26;
    localparam int DATA_W     = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/vga_prio_pick.sv
// vga_prio_pick: combinational lowest-index-first selector.
//   req    in  N      request bits
//   any    out 1      at least one request bit is set
//   idx    out IDX_W  index of the lowest set bit (0 when none)
//   onehot out N      one-hot of the lowest set bit (0 when none)
module vga_prio_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    output logic             any,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    assign any = |req;

    // Two's-complement trick isolates the lowest set bit.
    assign onehot = req & (~req + N'(1));

    // Scan from the top so the lowest set bit is the last to win.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/vga_fetch_arbiter.sv
// vga_fetch_arbiter: gathers the per-layer memory fetches of one pixel onto a
// single shared read port, stalling the pixel pipeline until every requested
// word has returned, then presents all words together as one p3 result.
//   clk, reset            clock, synchronous active-high reset
//   p2_pixel/valid/addr   pixel strobe, per-layer request bits and byte addresses
//   stall                 freezes the whole pixel pipeline while not IDLE
//   mem_req/addr/tag/ack  read request channel (tag = layer index)
//   mem_rvalid/rtag/rdata read response channel, any order
//   p3_valid/mask         one-cycle result strobe and layers that hold data
//   p3_data/lane          per-layer fetched word and byte lane p2_addr[1:0]
//   err_tag               sticky: a response arrived for a tag not outstanding
module vga_fetch_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int TAG_W      = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         p2_pixel,
    input  logic [NUM_LAYERS-1:0]        p2_valid,
    input  logic [NUM_LAYERS*ADDR_W-1:0] p2_addr,
    output logic                         stall,
    output logic                         mem_req,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [TAG_W-1:0]             mem_tag,
    input  logic                         mem_ack,
    input  logic                         mem_rvalid,
    input  logic [TAG_W-1:0]             mem_rtag,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         p3_valid,
    output logic [NUM_LAYERS-1:0]        p3_mask,
    output logic [NUM_LAYERS*DATA_W-1:0] p3_data,
    output logic [NUM_LAYERS*2-1:0]      p3_lane,
    output logic                         err_tag
);

    state_t                  state, next_state;
    logic [NUM_LAYERS-1:0]   pending, outstanding;
    logic [NUM_LAYERS*ADDR_W-1:0] addr_q;

    logic                    pick_any;
    logic [TAG_W-1:0]        pick_idx;
    logic [NUM_LAYERS-1:0]   pick_oh;

    logic                    capture, empty_px;
    logic [NUM_LAYERS-1:0]   ack_oh, resp_oh, out_next;
    logic [(2**TAG_W)-1:0]   tag_live;
    logic                    resp_hit;

    vga_prio_pick #(.N(NUM_LAYERS), .IDX_W(TAG_W)) u_pick (
        .req    (pending),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    assign capture  = (state == IDLE) && p2_pixel && (|p2_valid);
    assign empty_px = (state == IDLE) && p2_pixel && !(|p2_valid);
    assign ack_oh   = (state == ISSUE && mem_ack) ? pick_oh : '0;

    // A layer acked this cycle already counts as outstanding, so a memory
    // that answers in the ack cycle itself is accepted rather than flagged.
    always_comb begin
        tag_live = '0;
        tag_live[NUM_LAYERS-1:0] = outstanding | ack_oh;
    end

    assign resp_hit = mem_rvalid && tag_live[mem_rtag];

    always_comb begin
        resp_oh = '0;
        for (int i = 0; i < NUM_LAYERS; i++)
            resp_oh[i] = resp_hit && (mem_rtag == TAG_W'(i));
    end

    assign out_next = (outstanding | ack_oh) & ~resp_oh;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (capture) next_state = ISSUE;
            ISSUE: begin
                if (mem_ack && ((pending & ~ack_oh) == '0))
                    next_state = (out_next == '0) ? DONE : WAIT;
            end
            WAIT:  if (out_next == '0) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        stall   = (state != IDLE);
        mem_req = (state == ISSUE) && pick_any;
    end

    // pending only changes on an ack, so the presented layer is stable
    // while the request waits.
    assign mem_tag  = pick_idx;
    assign mem_addr = {addr_q[int'(pick_idx)*ADDR_W + 2 +: ADDR_W-2], 2'b00};

    // ---------------- control registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pending     <= '0;
            outstanding <= '0;
            err_tag     <= 1'b0;
            p3_valid    <= 1'b0;
        end else begin
            pending     <= capture ? p2_valid : (pending & ~ack_oh);
            outstanding <= out_next;
            err_tag     <= err_tag | (mem_rvalid && !resp_hit);
            p3_valid    <= empty_px || (next_state == DONE);
        end
    end

    // ---------------- result datapath (not reset) ----------------
    always_ff @(posedge clk) begin
        if ((state == IDLE) && p2_pixel)
            p3_mask <= p2_valid;
        if (capture) begin
            addr_q <= p2_addr;
            for (int i = 0; i < NUM_LAYERS; i++)
                p3_lane[i*2 +: 2] <= p2_addr[i*ADDR_W +: 2];
        end
        for (int i = 0; i < NUM_LAYERS; i++)
            if (resp_oh[i]) p3_data[i*DATA_W +: DATA_W] <= mem_rdata;
    end

endmodule

// File: tb/tb_vga_fetch_arbiter.sv
// Directed bench for vga_fetch_arbiter (4 layers, 2-bit tags). The memory
// side is driven by hand, one response per cycle, and every expected value
// below is worked out from the stimulus.
module tb_vga_fetch_arbiter;

    localparam int NL = 4;
    localparam int TW = 2;
    localparam int AW = 26;

    logic              clk = 1'b0;
    logic              reset;
    logic              p2_pixel;
    logic [NL-1:0]     p2_valid;
    logic [NL*AW-1:0]  p2_addr;
    logic              stall, mem_req;
    logic [AW-1:0]     mem_addr;
    logic [TW-1:0]     mem_tag;
    logic              mem_ack, mem_rvalid;
    logic [TW-1:0]     mem_rtag;
    logic [31:0]       mem_rdata;
    logic              p3_valid;
    logic [NL-1:0]     p3_mask;
    logic [NL*32-1:0]  p3_data;
    logic [NL*2-1:0]   p3_lane;
    logic              err_tag;

    int checks = 0;
    int errors = 0;

    vga_fetch_arbiter #(.NUM_LAYERS(NL), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset),
        .p2_pixel(p2_pixel), .p2_valid(p2_valid), .p2_addr(p2_addr),
        .stall(stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_tag(mem_tag), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rtag(mem_rtag), .mem_rdata(mem_rdata),
        .p3_valid(p3_valid), .p3_mask(p3_mask), .p3_data(p3_data), .p3_lane(p3_lane),
        .err_tag(err_tag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        p2_pixel   = 1'b0;
        p2_valid   = '0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rtag   = '0;
        mem_rdata  = '0;
    endtask

    initial begin : stim
        logic [AW-1:0] exp_addr [4];
        logic [31:0]   rdat     [4];
        int            order    [4];

        reset   = 1'b1;
        p2_addr = '0;
        idle_inputs();
        tick();
        tick();
        chk("rst_stall",   128'(stall),    128'(0));
        chk("rst_mem_req", 128'(mem_req),  128'(0));
        chk("rst_p3_valid",128'(p3_valid), 128'(0));
        chk("rst_err_tag", 128'(err_tag),  128'(0));
        reset = 1'b0;
        tick();

        // p2_valid ignored without p2_pixel
        p2_valid = 4'b1111;
        tick();
        p2_valid = '0;
        chk("nopix_stall",    128'(stall),    128'(0));
        chk("nopix_p3_valid", 128'(p3_valid), 128'(0));

        // empty pixel: immediate result, no stall
        p2_pixel = 1'b1;
        p2_valid = 4'b0000;
        chk("empty_stall0", 128'(stall), 128'(0));
        tick();
        p2_pixel = 1'b0;
        chk("empty_p3_valid", 128'(p3_valid), 128'(1));
        chk("empty_p3_mask",  128'(p3_mask),  128'(0));
        chk("empty_stall1",   128'(stall),    128'(0));
        tick();
        chk("empty_p3_drop",  128'(p3_valid), 128'(0));

        // layers 0 and 2, response one cycle after each ack
        p2_pixel = 1'b1;
        p2_valid = 4'b0101;
        p2_addr  = '0;
        p2_addr[0*AW +: AW] = 26'h100;
        p2_addr[1*AW +: AW] = 26'h3FF;
        p2_addr[2*AW +: AW] = 26'h20A;
        p2_addr[3*AW +: AW] = 26'h555;
        tick();                                    // capture edge
        idle_inputs();
        chk("l02_stall",   128'(stall),    128'(1));
        chk("l02_req0",    128'(mem_req),  128'(1));
        chk("l02_addr0",   128'(mem_addr), 128'(26'h100));
        chk("l02_tag0",    128'(mem_tag),  128'(0));
        mem_ack = 1'b1;
        tick();
        chk("l02_req1",    128'(mem_req),  128'(1));
        chk("l02_addr2",   128'(mem_addr), 128'(26'h208));
        chk("l02_tag2",    128'(mem_tag),  128'(2));
        mem_rvalid = 1'b1; mem_rtag = 2'd0; mem_rdata = 32'hA0A0_0000;
        tick();
        chk("l02_wait_req",   128'(mem_req),  128'(0));
        chk("l02_wait_stall", 128'(stall),    128'(1));
        chk("l02_wait_p3",    128'(p3_valid), 128'(0));
        mem_ack = 1'b0;
        mem_rvalid = 1'b1; mem_rtag = 2'd2; mem_rdata = 32'hC2C2_2222;
        tick();                                    // fourth cycle after capture
        idle_inputs();
        chk("l02_p3_valid", 128'(p3_valid),        128'(1));
        chk("l02_mask",     128'(p3_mask),         128'(4'b0101));
        chk("l02_data0",    128'(p3_data[31:0]),   128'(32'hA0A0_0000));
        chk("l02_data2",    128'(p3_data[95:64]),  128'(32'hC2C2_2222));
        chk("l02_lane0",    128'(p3_lane[1:0]),    128'(0));
        chk("l02_lane2",    128'(p3_lane[5:4]),    128'(2));
        tick();
        chk("l02_p3_drop",  128'(p3_valid), 128'(0));
        chk("l02_release",  128'(stall),    128'(0));

        // all four layers, responses out of order 3,1,0,2
        exp_addr[0] = 26'h1000; exp_addr[1] = 26'h2004;
        exp_addr[2] = 26'h3008; exp_addr[3] = 26'h400C;
        rdat[0] = 32'hD000_0000; rdat[1] = 32'hD111_1111;
        rdat[2] = 32'hD222_2222; rdat[3] = 32'hD333_3333;
        order[0] = 3; order[1] = 1; order[2] = 0; order[3] = 2;
        p2_pixel = 1'b1;
        p2_valid = 4'b1111;
        p2_addr[0*AW +: AW] = 26'h1000;
        p2_addr[1*AW +: AW] = 26'h2005;
        p2_addr[2*AW +: AW] = 26'h3008;
        p2_addr[3*AW +: AW] = 26'h400F;
        tick();
        idle_inputs();
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("all_tag%0d", i),  128'(mem_tag),  128'(i));
            chk($sformatf("all_addr%0d", i), 128'(mem_addr), 128'(exp_addr[i]));
            tick();
        end
        mem_ack = 1'b0;
        chk("all_wait_req", 128'(mem_req), 128'(0));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("all_p3_early%0d", i), 128'(p3_valid), 128'(0));
            mem_rvalid = 1'b1;
            mem_rtag   = TW'(order[i]);
            mem_rdata  = rdat[order[i]];
            tick();
        end
        idle_inputs();
        chk("all_p3_valid", 128'(p3_valid), 128'(1));
        chk("all_mask",     128'(p3_mask),  128'(4'b1111));
        chk("all_data",     128'(p3_data),
            {32'hD333_3333, 32'hD222_2222, 32'hD111_1111, 32'hD000_0000});
        chk("all_lane",     128'(p3_lane),  128'(8'hC4));
        chk("all_err",      128'(err_tag),  128'(0));
        tick();

        // ack withheld five cycles on layer 1
        p2_pixel = 1'b1;
        p2_valid = 4'b0010;
        p2_addr[1*AW +: AW] = 26'h12345;
        tick();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold_req%0d", i),   128'(mem_req),  128'(1));
            chk($sformatf("hold_addr%0d", i),  128'(mem_addr), 128'(26'h12344));
            chk($sformatf("hold_tag%0d", i),   128'(mem_tag),  128'(1));
            chk($sformatf("hold_stall%0d", i), 128'(stall),    128'(1));
            tick();
        end
        chk("hold_addr_ack", 128'(mem_addr), 128'(26'h12344));
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("hold_wait_req", 128'(mem_req), 128'(0));
        mem_rvalid = 1'b1; mem_rtag = 2'd1; mem_rdata = 32'h5555_AAAA;
        tick();
        idle_inputs();
        chk("hold_p3_valid", 128'(p3_valid),       128'(1));
        chk("hold_mask",     128'(p3_mask),        128'(4'b0010));
        chk("hold_data1",    128'(p3_data[63:32]), 128'(32'h5555_AAAA));
        chk("hold_lane1",    128'(p3_lane[3:2]),   128'(1));
        tick();

        // stray response: sticky error, results untouched
        chk("stray_err0", 128'(err_tag), 128'(0));
        mem_rvalid = 1'b1; mem_rtag = 2'd3; mem_rdata = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        chk("stray_err1",  128'(err_tag),  128'(1));
        chk("stray_p3",    128'(p3_valid), 128'(0));
        chk("stray_stall", 128'(stall),    128'(0));
        tick();
        tick();
        chk("stray_sticky", 128'(err_tag), 128'(1));
        chk("stray_data",   128'(p3_data),
            {32'hD333_3333, 32'hD222_2222, 32'h5555_AAAA, 32'hD000_0000});

        // reset while two layers are outstanding
        p2_pixel = 1'b1;
        p2_valid = 4'b0011;
        p2_addr[0*AW +: AW] = 26'h40;
        p2_addr[1*AW +: AW] = 26'h80;
        tick();
        idle_inputs();
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        chk("rstmid_wait_stall", 128'(stall),   128'(1));
        chk("rstmid_wait_req",   128'(mem_req), 128'(0));
        reset = 1'b1;
        tick();
        chk("rstmid_stall", 128'(stall),    128'(0));
        chk("rstmid_req",   128'(mem_req),  128'(0));
        chk("rstmid_p3",    128'(p3_valid), 128'(0));
        chk("rstmid_err",   128'(err_tag),  128'(0));
        reset = 1'b0;

        // next pixel after reset; ack and response land in the same cycle
        p2_pixel = 1'b1;
        p2_valid = 4'b1000;
        p2_addr[3*AW +: AW] = 26'h7F3;
        tick();
        idle_inputs();
        chk("post_req",  128'(mem_req),  128'(1));
        chk("post_addr", 128'(mem_addr), 128'(26'h7F0));
        chk("post_tag",  128'(mem_tag),  128'(3));
        mem_ack = 1'b1;
        mem_rvalid = 1'b1; mem_rtag = 2'd3; mem_rdata = 32'h1234_5678;
        tick();
        idle_inputs();
        chk("post_p3_valid", 128'(p3_valid),        128'(1));
        chk("post_mask",     128'(p3_mask),         128'(4'b1000));
        chk("post_data3",    128'(p3_data[127:96]), 128'(32'h1234_5678));
        chk("post_lane3",    128'(p3_lane[7:6]),    128'(3));
        chk("post_err",      128'(err_tag),         128'(0));
        tick();
        chk("post_release",  128'(stall), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
